stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/stopwatch_btn_debounce.sv | 41 ++++
 rtl/stopwatch_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: FSM state encoding and time-field widths.
package stopwatch_pkg;

  localparam int MS_W  = 12;
  localparam int SEC_W = 8;
  localparam int MIN_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STOPPED = 2'd2,
    ST_LAP     = 2'd3
  } sw_state_t;

endpackage

// File: rtl/stopwatch_btn_debounce.sv
// Button conditioning: 2-FF synchroniser, stability-count debouncer and
// a one-cycle press strobe on each debounced 0->1 edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // cnt counts consecutive synchronised samples that disagree with level;
  // the level flips on the DEBOUNCE_CYCLES-th such sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      pulse <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        pulse <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM with debounced buttons and lap-freeze display.
// Lap feature is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_ss,
  input  logic             btn_lr,
  input  logic [MS_W-1:0]  cnt_ms,
  input  logic [SEC_W-1:0] cnt_sec,
  input  logic [MIN_W-1:0] cnt_min,
  output logic             pause,
  output logic             clear_n,
  output logic [MS_W-1:0]  disp_ms,
  output logic [SEC_W-1:0] disp_sec,
  output logic [MIN_W-1:0] disp_min,
  output logic [1:0]       state,
  output logic             lap_active
);

  // ss_pulse / lr_pulse are single-cycle strobes: valid for one cycle,
  // always accepted by the FSM, no backpressure; ss wins a tie.
  logic      ss_pulse, lr_pulse;
  logic      ss_level, lr_level;
  sw_state_t st;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
    .clk(clk), .rst(rst), .btn(btn_ss), .level(ss_level), .pulse(ss_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lr (
    .clk(clk), .rst(rst), .btn(btn_lr), .level(lr_level), .pulse(lr_pulse)
  );

  assign state = st;

`ifdef STOPWATCH_LAP_EN
  logic [MS_W-1:0]  lap_ms;
  logic [SEC_W-1:0] lap_sec;
  logic [MIN_W-1:0] lap_min;
  logic             lap_q;

  assign lap_active = lap_q;
`else
  assign lap_active = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_IDLE;
      pause    <= 1'b1;
      clear_n  <= 1'b0;
      disp_ms  <= '0;
      disp_sec <= '0;
      disp_min <= '0;
`ifdef STOPWATCH_LAP_EN
      lap_ms   <= '0;
      lap_sec  <= '0;
      lap_min  <= '0;
      lap_q    <= 1'b0;
`endif
    end else begin
      clear_n <= 1'b1;
      pause   <= (st == ST_IDLE) || (st == ST_STOPPED);
`ifdef STOPWATCH_LAP_EN
      if (st == ST_LAP) begin
        disp_ms  <= lap_ms;
        disp_sec <= lap_sec;
        disp_min <= lap_min;
      end else begin
        disp_ms  <= cnt_ms;
        disp_sec <= cnt_sec;
        disp_min <= cnt_min;
      end
`else
      disp_ms  <= cnt_ms;
      disp_sec <= cnt_sec;
      disp_min <= cnt_min;
`endif
      case (st)
        ST_IDLE: begin
          if (ss_pulse) st <= ST_RUN;
        end
        ST_RUN: begin
          if (ss_pulse) begin
            st <= ST_STOPPED;
`ifdef STOPWATCH_LAP_EN
          end else if (lr_pulse) begin
            st      <= ST_LAP;
            lap_q   <= 1'b1;
            lap_ms  <= cnt_ms;
            lap_sec <= cnt_sec;
            lap_min <= cnt_min;
`endif
          end
        end
        ST_STOPPED: begin
          if (ss_pulse) begin
            st <= ST_RUN;
          end else if (lr_pulse) begin
            st      <= ST_IDLE;
            clear_n <= 1'b0;
          end
        end
`ifdef STOPWATCH_LAP_EN
        ST_LAP: begin
          if (ss_pulse) begin
            st    <= ST_STOPPED;
            lap_q <= 1'b0;
          end else if (lr_pulse) begin
            lap_ms  <= cnt_ms;
            lap_sec <= cnt_sec;
            lap_min <= cnt_min;
          end
        end
`endif
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule
